rr_mux_arb: RTL and testbench



---
 rtl/rr_mux_arb.sv | 141 ++++++++++++++
 tb/tb_rr_mux_arb.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arb.sv
// N-channel valid/ready arbiter feeding one registered output stage, round-robin or fixed priority.
// Optional packet locking (grant held until in_last) is enabled by defining RR_MUX_PACKET_LOCK_EN.
module rr_mux_arb #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mode,
  input  logic [N-1:0]      in_valid,
  input  logic [N*W-1:0]    in_data,
  output logic [N-1:0]      in_ready,
`ifdef RR_MUX_PACKET_LOCK_EN
  input  logic [N-1:0]      in_last,
  output logic              out_last,
`endif
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_sel,
  input  logic              out_ready
);

  logic            r_valid;
  logic [W-1:0]    r_data;
  logic [SELW-1:0] r_sel;
  logic [SELW-1:0] r_ptr;

  logic            w_load;
  logic            w_arb_any;
  logic [SELW-1:0] w_arb_grant;
  logic [SELW-1:0] w_grant;
  logic            w_req;
  logic            w_xfer;
  logic [W-1:0]    w_data;
  logic [SELW-1:0] w_next_ptr;
  int              w_best_dist;

  // Distance of a channel from the search start; lower wins.
  function automatic int arb_dist(input int idx, input logic m, input logic [SELW-1:0] p);
    return m ? idx : (idx + N - int'(p)) % N;
  endfunction

  assign w_load = !r_valid || out_ready;

  always_comb begin
    w_arb_grant = '0;
    w_arb_any   = 1'b0;
    w_best_dist = N;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && (arb_dist(i, mode, r_ptr) < w_best_dist)) begin
        w_best_dist = arb_dist(i, mode, r_ptr);
        w_arb_grant = SELW'(i);
        w_arb_any   = 1'b1;
      end
    end
  end

`ifdef RR_MUX_PACKET_LOCK_EN
  logic            r_locked;
  logic [SELW-1:0] r_lock_ch;
  logic            r_last;
  logic            w_lock_valid;
  logic            w_last_g;

  always_comb begin
    w_lock_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (r_lock_ch == SELW'(i)) w_lock_valid = in_valid[i];
    end
  end

  // A locked grant stays on its channel even when that channel is idle.
  assign w_grant = r_locked ? r_lock_ch : w_arb_grant;
  assign w_req   = r_locked ? w_lock_valid : w_arb_any;

  always_comb begin
    w_last_g = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SELW'(i)) w_last_g = in_last[i];
    end
  end

  assign out_last = r_last;
`else
  assign w_grant = w_arb_grant;
  assign w_req   = w_arb_any;
`endif

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant == SELW'(i)) w_data = in_data[i*W +: W];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = reset_n && w_load && w_req && (w_grant == SELW'(i));
    end
  end

  assign w_xfer     = w_load && w_req;
  assign w_next_ptr = SELW'((int'(w_grant) + 1) % N);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
`ifdef RR_MUX_PACKET_LOCK_EN
      r_locked  <= 1'b0;
      r_lock_ch <= '0;
      r_last    <= 1'b0;
`endif
    end else if (w_load) begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= w_data;
        r_sel   <= w_grant;
`ifdef RR_MUX_PACKET_LOCK_EN
        r_last    <= w_last_g;
        r_locked  <= !w_last_g;
        r_lock_ch <= w_grant;
        if (!mode && w_last_g) r_ptr <= w_next_ptr;
`else
        if (!mode) r_ptr <= w_next_ptr;
`endif
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb (N=4, W=8): reset, round-robin, fixed priority, backpressure,
// wrap-around, idle, mid-stream reset and, when RR_MUX_PACKET_LOCK_EN is defined, packet lock.
module tb_rr_mux_arb;

  logic        clk;
  logic        reset_n;
  logic        mode;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;
`ifdef RR_MUX_PACKET_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rr_mux_arb #(.N(4), .W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef RR_MUX_PACKET_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] s);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".sel"},   32'(out_sel),   32'(s));
    $display("%0t %s: valid=%0d data=%02h sel=%0d", $time, tag, out_valid, out_data, out_sel);
  endtask

  initial begin
    reset_n   = 1'b0;
    mode      = 1'b0;
    in_valid  = 4'hF;
    in_data   = 32'hA3A2A1A0;
    out_ready = 1'b1;
`ifdef RR_MUX_PACKET_LOCK_EN
    in_last   = 4'hF;
`endif
    #2;
    chk_out("reset", 1'b0, 8'h00, 2'd0);
    chk("reset.in_ready", 32'(in_ready), 32'h0);
    step();
    step();
    reset_n  = 1'b1;
    in_valid = 4'h0;
    step();
    chk_out("idle_after_reset", 1'b0, 8'h00, 2'd0);

    // Round-robin over all four channels, ptr starts at 0
    in_valid = 4'hF;
    #1;
    chk("rr.in_ready0", 32'(in_ready), 32'h1);
    step();
    chk_out("rr0", 1'b1, 8'hA0, 2'd0);
    #1;
    chk("rr.in_ready1", 32'(in_ready), 32'h2);
    step();
    chk_out("rr1", 1'b1, 8'hA1, 2'd1);
    step();
    chk_out("rr2", 1'b1, 8'hA2, 2'd2);
    step();
    chk_out("rr3", 1'b1, 8'hA3, 2'd3);
    step();
    chk_out("rr4", 1'b1, 8'hA0, 2'd0);

    // Fixed priority, channel 3 starved; ptr stays at 1
    mode     = 1'b1;
    in_valid = 4'b1010;
    #1;
    chk("fp.in_ready", 32'(in_ready), 32'h2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("fp", 1'b1, 8'hA1, 2'd1);
    end

    // Backpressure: output frozen, no in_ready, new data on ch1 must not leak
    out_ready      = 1'b0;
    mode           = 1'b0;
    in_valid       = 4'hF;
    in_data[15:8]  = 8'hB1;
    #1;
    chk("bp.in_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("bp_hold", 1'b1, 8'hA1, 2'd1);
      chk("bp_hold.in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", 32'(in_ready), 32'h2);
    step();
    chk_out("bp_release", 1'b1, 8'hB1, 2'd1);
    step();
    chk_out("bp_nobubble", 1'b1, 8'hA2, 2'd2);

    // Wrap-around from ptr=3 with sparse inputs
    in_valid = 4'b0011;
    #1;
    chk("wrap.in_ready", 32'(in_ready), 32'h1);
    step();
    chk_out("wrap", 1'b1, 8'hA0, 2'd0);
    #1;
    chk("wrap_ptr1.in_ready", 32'(in_ready), 32'h2);
    step();
    chk_out("wrap_next", 1'b1, 8'hB1, 2'd1);

    // Idle: valid drops, data and sel hold
    in_valid = 4'h0;
    #1;
    chk("idle.in_ready", 32'(in_ready), 32'h0);
    step();
    chk_out("idle", 1'b0, 8'hB1, 2'd1);

    // Reset asserted while a beat is held
    in_valid = 4'hF;
    step();
    chk_out("pre_reset", 1'b1, 8'hA2, 2'd2);
    reset_n = 1'b0;
    #1;
    chk_out("mid_reset", 1'b0, 8'h00, 2'd0);
    chk("mid_reset.in_ready", 32'(in_ready), 32'h0);
    step();
    reset_n = 1'b1;
    #1;
    chk("post_reset.in_ready", 32'(in_ready), 32'h1);
    step();
    chk_out("post_reset", 1'b1, 8'hA0, 2'd0);

`ifdef RR_MUX_PACKET_LOCK_EN
    // ptr=1: channel 2 wins, then locks until its last beat
    in_valid = 4'b0101;
    in_last  = 4'b0000;
    #1;
    chk("lock.in_ready0", 32'(in_ready), 32'h4);
    step();
    chk_out("lock0", 1'b1, 8'hA2, 2'd2);
    chk("lock0.last", 32'(out_last), 32'h0);
    #1;
    chk("lock.in_ready1", 32'(in_ready), 32'h4);
    step();
    chk_out("lock1", 1'b1, 8'hA2, 2'd2);
    in_last = 4'b0100;
    step();
    chk_out("lock2", 1'b1, 8'hA2, 2'd2);
    chk("lock2.last", 32'(out_last), 32'h1);
    in_last = 4'hF;
    step();
    chk_out("unlock", 1'b1, 8'hA0, 2'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
